countdown_timer_bank: RTL and testbench

Parametrised bank of independent down-counters driving the timed phases of the airlock controller, such as evacuate and pressurize. Each channel loads a programmable count on a start pulse and decrements once per clock. On reaching zero it emits a one-cycle `done` pulse. It replaces the single fixed-length evacuate countdown with per-channel load values, a global hold, per-channel abort, and optional retrigger.

---
 rtl/countdown_pkg.sv | 25 ++
 rtl/countdown_channel.sv | 91 +++++++++
 rtl/countdown_timer_bank.sv | 37 +++
 tb/tb_countdown_timer_bank.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer bank: channel state encoding
// and the default counter width.
package countdown_pkg;

   // Default counter width used when the bank is instantiated without override.
   localparam int DEFAULT_WIDTH = 8;

   // Per-channel FSM state.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cd_state_e;

   // State entered when a channel accepts a new load value: a zero load
   // expires at once, anything else starts counting.
   function automatic cd_state_e load_state(input logic load_is_zero);
      if (load_is_zero) begin
         return DONE;
      end else begin
         return RUN;
      end
   endfunction

endpackage

// File: rtl/countdown_channel.sv
// One countdown channel: three-state FSM (IDLE/RUN/DONE) plus down-counter.
// Build option: COUNTDOWN_RETRIGGER_EN lets a start while running reload the
// counter; without it a start during RUN is ignored.
module countdown_channel
   import countdown_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             abort_i,
   input  logic             hold_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] count_o
);

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   cd_state_e        state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             load_zero_s;

   assign load_zero_s = (load_val_i == CNT_ZERO);

   // Next-state and next-count logic; abort overrides start and expiry.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (abort_i) begin
         state_d = IDLE;
         count_d = CNT_ZERO;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               // DONE lasts one cycle; a start here is a back-to-back restart.
               if (start_i) begin
                  state_d = load_state(load_zero_s);
                  count_d = load_val_i;
               end else begin
                  state_d = IDLE;
                  count_d = CNT_ZERO;
               end
            end
            RUN: begin
`ifdef COUNTDOWN_RETRIGGER_EN
               if (start_i) begin
                  // Reload ignores hold; the interrupted run never signals done.
                  state_d = load_state(load_zero_s);
                  count_d = load_val_i;
               end else
`endif
               if (hold_i) begin
                  state_d = RUN;
                  count_d = count_q;
               end else if (count_q <= CNT_ONE) begin
                  // Expire on the 1->0 step; never wrap below zero.
                  state_d = DONE;
                  count_d = CNT_ZERO;
               end else begin
                  state_d = RUN;
                  count_d = count_q - CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               count_d = CNT_ZERO;
            end
         endcase
      end
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         count_q <= CNT_ZERO;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign busy_o  = (state_q == RUN);
   assign done_o  = (state_q == DONE);
   assign count_o = count_q;

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of CHANNELS independent countdown timers sharing a global hold.
// Build option: COUNTDOWN_RETRIGGER_EN (see countdown_channel) enables reload
// of a running channel on start.
module countdown_timer_bank
   import countdown_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = DEFAULT_WIDTH
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic [CHANNELS-1:0]       start,
   input  logic [CHANNELS*WIDTH-1:0] load_val,
   input  logic [CHANNELS-1:0]       abort,
   input  logic                      hold,
   output logic [CHANNELS-1:0]       busy,
   output logic [CHANNELS-1:0]       done,
   output logic [CHANNELS*WIDTH-1:0] count
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      countdown_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk_i      (Clock),
         .rst_i      (Reset),
         .start_i    (start[i]),
         .load_val_i (load_val[i*WIDTH +: WIDTH]),
         .abort_i    (abort[i]),
         .hold_i     (hold),
         .busy_o     (busy[i]),
         .done_o     (done[i]),
         .count_o    (count[i*WIDTH +: WIDTH])
      );
   end

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Self-checking bench for countdown_timer_bank (CHANNELS=2, WIDTH=8).
// Per-cycle vector table plus hand sequences for reset and retrigger.
module tb_countdown_timer_bank;

   logic        Clock;
   logic        Reset;
   logic [1:0]  start;
   logic [15:0] load_val;
   logic [1:0]  abort;
   logic        hold;
   logic [1:0]  busy;
   logic [1:0]  done;
   logic [15:0] count;

   int checks;
   int failures;

   typedef struct {
      string       name;
      logic [1:0]  st;
      logic [15:0] ld;
      logic [1:0]  ab;
      logic        hd;
      logic [1:0]  e_busy;
      logic [1:0]  e_done;
      logic [15:0] e_count;
   } vec_t;

   vec_t vecs[$];

   countdown_timer_bank #(
      .CHANNELS (2),
      .WIDTH    (8)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .start    (start),
      .load_val (load_val),
      .abort    (abort),
      .hold     (hold),
      .busy     (busy),
      .done     (done),
      .count    (count)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic vec_t mk(string n, logic [1:0] s, logic [7:0] l1, logic [7:0] l0,
                               logic [1:0] a, logic h, logic [1:0] eb, logic [1:0] ed,
                               logic [7:0] c1, logic [7:0] c0);
      vec_t v;
      v.name = n; v.st = s; v.ld = {l1, l0}; v.ab = a; v.hd = h;
      v.e_busy = eb; v.e_done = ed; v.e_count = {c1, c0};
      return v;
   endfunction

   task automatic check(input string n, input logic [1:0] eb, input logic [1:0] ed,
                        input logic [15:0] ec);
      checks++;
      if (busy !== eb || done !== ed || count !== ec) begin
         failures++;
         $display("FAIL %s: got busy=%b done=%b count=%h, want busy=%b done=%b count=%h",
                  n, busy, done, count, eb, ed, ec);
      end
   endtask

   // Drive inputs, advance one rising edge, settle just after it.
   task automatic step(input logic [1:0] s, input logic [15:0] l, input logic [1:0] a,
                       input logic h);
      start = s; load_val = l; abort = a; hold = h;
      @(posedge Clock);
      #1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      Reset = 1'b1;
      start = 2'b00; load_val = 16'h0000; abort = 2'b00; hold = 1'b0;

      // Basic run CH0 L=5
      vecs.push_back(mk("run_load",  2'b01, 8'd0, 8'd5, 2'b00, 1'b0, 2'b01, 2'b00, 8'd0, 8'd5));
      vecs.push_back(mk("run_c4",    2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b01, 2'b00, 8'd0, 8'd4));
      vecs.push_back(mk("run_c3",    2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b01, 2'b00, 8'd0, 8'd3));
      vecs.push_back(mk("run_c2",    2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b01, 2'b00, 8'd0, 8'd2));
      vecs.push_back(mk("run_c1",    2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b01, 2'b00, 8'd0, 8'd1));
      vecs.push_back(mk("run_done",  2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b00, 2'b01, 8'd0, 8'd0));
      vecs.push_back(mk("run_idle",  2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b00, 2'b00, 8'd0, 8'd0));
      // CH1 L=3 with 2 hold cycles, CH0 L=0 at the same edge
      vecs.push_back(mk("hz_load",   2'b11, 8'd3, 8'd0, 2'b00, 1'b0, 2'b10, 2'b01, 8'd3, 8'd0));
      vecs.push_back(mk("hz_hold1",  2'b00, 8'd0, 8'd0, 2'b00, 1'b1, 2'b10, 2'b00, 8'd3, 8'd0));
      vecs.push_back(mk("hz_hold2",  2'b00, 8'd0, 8'd0, 2'b00, 1'b1, 2'b10, 2'b00, 8'd3, 8'd0));
      vecs.push_back(mk("hz_c2",     2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b10, 2'b00, 8'd2, 8'd0));
      vecs.push_back(mk("hz_c1",     2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b10, 2'b00, 8'd1, 8'd0));
      vecs.push_back(mk("hz_done",   2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b00, 2'b10, 8'd0, 8'd0));
      vecs.push_back(mk("hz_idle",   2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b00, 2'b00, 8'd0, 8'd0));
      // Staggered concurrent runs
      vecs.push_back(mk("ind_ld0",   2'b01, 8'd9, 8'd4, 2'b00, 1'b0, 2'b01, 2'b00, 8'd0, 8'd4));
      vecs.push_back(mk("ind_ld1",   2'b10, 8'd2, 8'd7, 2'b00, 1'b0, 2'b11, 2'b00, 8'd2, 8'd3));
      vecs.push_back(mk("ind_c",     2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'd1, 8'd2));
      vecs.push_back(mk("ind_d1",    2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b01, 2'b10, 8'd0, 8'd1));
      vecs.push_back(mk("ind_d0",    2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b00, 2'b01, 8'd0, 8'd0));
      vecs.push_back(mk("ind_idle",  2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b00, 2'b00, 8'd0, 8'd0));
      // Abort priority
      vecs.push_back(mk("ab_vs_st",  2'b01, 8'd0, 8'd9, 2'b01, 1'b0, 2'b00, 2'b00, 8'd0, 8'd0));
      vecs.push_back(mk("ab_load",   2'b01, 8'd0, 8'd2, 2'b00, 1'b0, 2'b01, 2'b00, 8'd0, 8'd2));
      vecs.push_back(mk("ab_c1",     2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b01, 2'b00, 8'd0, 8'd1));
      vecs.push_back(mk("ab_expiry", 2'b00, 8'd0, 8'd0, 2'b01, 1'b0, 2'b00, 2'b00, 8'd0, 8'd0));
      vecs.push_back(mk("ab_nodone", 2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b00, 2'b00, 8'd0, 8'd0));
      // Restart during DONE on CH1
      vecs.push_back(mk("rs_load",   2'b10, 8'd1, 8'd0, 2'b00, 1'b0, 2'b10, 2'b00, 8'd1, 8'd0));
      vecs.push_back(mk("rs_done1",  2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b00, 2'b10, 8'd0, 8'd0));
      vecs.push_back(mk("rs_restart",2'b10, 8'd2, 8'd0, 2'b00, 1'b0, 2'b10, 2'b00, 8'd2, 8'd0));
      vecs.push_back(mk("rs_c1",     2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b10, 2'b00, 8'd1, 8'd0));
      vecs.push_back(mk("rs_done2",  2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b00, 2'b10, 8'd0, 8'd0));
      vecs.push_back(mk("rs_idle",   2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 2'b00, 2'b00, 8'd0, 8'd0));
      // Start from IDLE accepted under hold, then frozen, then aborted
      vecs.push_back(mk("hi_load",   2'b01, 8'd0, 8'd3, 2'b00, 1'b1, 2'b01, 2'b00, 8'd0, 8'd3));
      vecs.push_back(mk("hi_frozen", 2'b00, 8'd0, 8'd0, 2'b00, 1'b1, 2'b01, 2'b00, 8'd0, 8'd3));
      vecs.push_back(mk("hi_abort",  2'b00, 8'd0, 8'd0, 2'b01, 1'b1, 2'b00, 2'b00, 8'd0, 8'd0));

      // Reset state
      repeat (2) @(posedge Clock);
      #1;
      check("reset_state", 2'b00, 2'b00, 16'h0000);
      Reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].st, vecs[i].ld, vecs[i].ab, vecs[i].hd);
         check(vecs[i].name, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_count);
      end
      step(2'b00, 16'h0000, 2'b00, 1'b0);

      // Reset mid-count: L=10, reset after 4 further edges
      step(2'b01, 16'h000A, 2'b00, 1'b0);
      repeat (4) step(2'b00, 16'h0000, 2'b00, 1'b0);
      check("rst_pre", 2'b01, 2'b00, 16'h0006);
      Reset = 1'b1;
      step(2'b00, 16'h0000, 2'b00, 1'b0);
      check("rst_mid", 2'b00, 2'b00, 16'h0000);
      Reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step(2'b00, 16'h0000, 2'b00, 1'b0);
         check("rst_no_done", 2'b00, 2'b00, 16'h0000);
      end

      // Start during RUN at count=2 with L=7
      step(2'b01, 16'h0004, 2'b00, 1'b0);
      step(2'b00, 16'h0000, 2'b00, 1'b0);
      step(2'b00, 16'h0000, 2'b00, 1'b0);
      check("rt_pre", 2'b01, 2'b00, 16'h0002);
      step(2'b01, 16'h0007, 2'b00, 1'b0);
`ifdef COUNTDOWN_RETRIGGER_EN
      check("rt_reload", 2'b01, 2'b00, 16'h0007);
      for (int k = 1; k < 7; k++) begin
         step(2'b00, 16'h0000, 2'b00, 1'b0);
         check("rt_count", 2'b01, 2'b00, 16'(7 - k));
      end
      step(2'b00, 16'h0000, 2'b00, 1'b0);
      check("rt_done", 2'b00, 2'b01, 16'h0000);
      step(2'b00, 16'h0000, 2'b00, 1'b0);
      check("rt_idle", 2'b00, 2'b00, 16'h0000);
`else
      check("rt_ignored", 2'b01, 2'b00, 16'h0001);
      step(2'b00, 16'h0000, 2'b00, 1'b0);
      check("rt_done", 2'b00, 2'b01, 16'h0000);
      for (int k = 0; k < 7; k++) begin
         step(2'b00, 16'h0000, 2'b00, 1'b0);
         check("rt_idle", 2'b00, 2'b00, 16'h0000);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
